// File: rtl/fact_host_master.sv
// Host-side bus master for the factorial subsystem: pushes a job's operands into
// the input FIFO, starts the engine, waits for its interrupt, then drains results.
module fact_host_master #(
  parameter logic [7:0]  FIFO_IN_PUSH = 8'h10,
  parameter logic [7:0]  FIFO_OUT_POP = 8'h20,
  parameter logic [7:0]  FACT_OPSTART = 8'h00,
  parameter logic [7:0]  FACT_INTRCLR = 8'h04,
  parameter int unsigned MAX_LEN      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  job_len,
  input  logic        op_valid,
  input  logic [31:0] op_data,
  output logic        op_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic        M0_req,
  output logic        M0_wr,
  output logic [7:0]  M0_address,
  output logic [31:0] M0_dout,
  input  logic        M0_grant,
  input  logic [31:0] M_din,
  input  logic        interrupt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_PUSH, S_GO, S_WAIT_IRQ,
    S_POP, S_CAPT, S_HOLD, S_CLR, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] res_q, res_d;
  logic        xfer_q, xfer_d;
  logic        irq_q, irq_d;
  logic        req_state;
  logic        xfer;
  logic [3:0]  cnt_inc;

  // xfer_q forces a one-cycle request gap after every transfer (matters for PUSH -> GO)
  always_comb begin
    req_state = (state_q == S_PUSH) || (state_q == S_GO) ||
                (state_q == S_POP)  || (state_q == S_CLR);
  end

  assign M0_req   = req_state & ~xfer_q;
  assign xfer     = M0_req & M0_grant;
  assign cnt_inc  = cnt_q + 4'd1;
  assign res_data = res_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    operand_d  = operand_q;
    res_d      = res_q;
    xfer_d     = xfer;
    irq_d      = 1'b0;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    M0_wr      = 1'b0;
    M0_address = 8'h00;
    M0_dout    = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && (job_len != 4'd0) && (32'(job_len) <= MAX_LEN)) begin
          len_d   = job_len;
          cnt_d   = 4'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        op_ready = 1'b1;
        if (op_valid) begin
          operand_d = op_data;
          state_d   = S_PUSH;
        end
      end
      S_PUSH: begin
        M0_wr      = 1'b1;
        M0_address = FIFO_IN_PUSH;
        M0_dout    = operand_q;
        if (xfer) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? S_GO : S_FETCH;
        end
      end
      S_GO: begin
        M0_wr      = 1'b1;
        M0_address = FACT_OPSTART;
        M0_dout    = 32'h1;
        if (xfer) begin
          cnt_d   = 4'd0;
          irq_d   = interrupt;
          state_d = S_WAIT_IRQ;
        end
      end
      S_WAIT_IRQ: begin
        if (interrupt || irq_q) state_d = S_POP;
      end
      S_POP: begin
        M0_address = FIFO_OUT_POP;
        if (xfer) state_d = S_CAPT;
      end
      S_CAPT: begin
        res_d   = M_din;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? S_CLR : S_POP;
        end
      end
      S_CLR: begin
        M0_wr      = 1'b1;
        M0_address = FACT_INTRCLR;
        M0_dout    = 32'h1;
        if (xfer) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      len_q     <= 4'd0;
      cnt_q     <= 4'd0;
      operand_q <= 32'h0;
      res_q     <= 32'h0;
      xfer_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      res_q     <= res_d;
      xfer_q    <= xfer_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_fact_host_master.sv
// Randomized bench for fact_host_master: a behavioural bus/FIFO/factorial model answers
// the master, and every job's bus writes, results, done and busy are checked against it.
module tb_fact_host_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  job_len = 4'd0;
  logic        op_valid = 1'b0;
  logic [31:0] op_data = 32'h0;
  logic        op_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        M0_req;
  logic        M0_wr;
  logic [7:0]  M0_address;
  logic [31:0] M0_dout;
  logic        M0_grant = 1'b0;
  logic [31:0] M_din = 32'h0;
  logic        interrupt = 1'b0;

  fact_host_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .job_len(job_len),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .done(done), .M0_req(M0_req), .M0_wr(M0_wr),
    .M0_address(M0_address), .M0_dout(M0_dout), .M0_grant(M0_grant),
    .M_din(M_din), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // environment knobs and model state
  int          gdelay = 0;
  bit          force_grant = 1'b0;
  bit          stall = 1'b0;
  bit          irq_early = 1'b0;
  bit          irq_block = 1'b0;
  logic [31:0] ops_in[$];
  logic [31:0] ops_pend[$];
  logic [31:0] fifo_m[$];
  logic [39:0] writes[$];
  logic [31:0] results[$];
  int          reads = 0;
  int          proto_viol = 0;
  int          hold_viol = 0;
  int          busy_drop = 0;
  int          done_cnt = 0;
  int          req_cnt = 0;
  bit          job_active = 1'b0;
  bit          in_wait = 1'b0;
  int          irq_delay = 0;

  // responder-private state
  bit          req_active = 1'b0;
  int          wait_cnt = 0;
  logic [40:0] hold_cmd = '0;
  bit          last_xfer = 1'b0;
  bit          rd_pending = 1'b0;
  logic [31:0] rd_value = '0;
  bit          res_prev_valid = 1'b0;
  bit          res_prev_acc = 1'b0;
  logic [31:0] res_prev_data = '0;
  int          stall_cnt = 0;

  function automatic logic [31:0] fact(input logic [31:0] x);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 2; k <= int'(x); k++) p = p * k;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Bus slave, factorial engine, operand source and result sink, all evaluated mid-cycle
  initial begin : responder
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        M0_grant = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        req_active = 1'b0; last_xfer = 1'b0; rd_pending = 1'b0;
        res_prev_valid = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (M0_req) req_cnt++;
        if (job_active) begin
          if (done) job_active = 1'b0;
          else if (!busy) busy_drop++;
        end
        if (rd_pending) begin
          M_din = rd_value;
          rd_pending = 1'b0;
        end else begin
          M_din = $urandom;
        end
        if (last_xfer && M0_req) proto_viol++;
        if (in_wait && M0_req) proto_viol++;
        last_xfer = 1'b0;
        M0_grant = force_grant;
        if (M0_req) begin
          if (!req_active) begin
            req_active = 1'b1;
            wait_cnt = 0;
            hold_cmd = {M0_wr, M0_address, M0_dout};
          end else if (hold_cmd != {M0_wr, M0_address, M0_dout}) begin
            proto_viol++;
          end
          if (force_grant || wait_cnt >= gdelay) begin
            M0_grant = 1'b1;
            req_active = 1'b0;
            last_xfer = 1'b1;
            if (M0_wr) begin
              writes.push_back({M0_address, M0_dout});
              if (M0_address == 8'h10) fifo_m.push_back(M0_dout);
              if (M0_address == 8'h00 && M0_dout == 32'h1) begin
                if (irq_early && !irq_block) interrupt = 1'b1;
                else begin
                  in_wait = 1'b1;
                  irq_delay = $urandom_range(0, 4);
                end
              end
              if (M0_address == 8'h04) interrupt = 1'b0;
            end else begin
              reads++;
              rd_pending = 1'b1;
              rd_value = (fifo_m.size() > 0) ? fact(fifo_m.pop_front()) : 32'hDEAD_BEEF;
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          req_active = 1'b0;
        end
        if (in_wait && !irq_block && !last_xfer) begin
          if (irq_delay == 0) begin
            interrupt = 1'b1;
            in_wait = 1'b0;
          end else begin
            irq_delay--;
          end
        end
        if (op_ready && ops_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          op_valid = 1'b1;
          op_data = ops_pend.pop_front();
        end else begin
          op_valid = 1'b0;
          op_data = $urandom;
        end
        if (res_valid) begin
          if (res_prev_valid && !res_prev_acc) begin
            if (res_data != res_prev_data) hold_viol++;
          end else begin
            stall_cnt = 0;
          end
          if (M0_req) hold_viol++;
          res_ready = stall ? (stall_cnt >= 5) : 1'($urandom_range(0, 1));
          if (!res_ready) stall_cnt++;
          if (res_ready) results.push_back(res_data);
          res_prev_valid = 1'b1;
          res_prev_acc = res_ready;
          res_prev_data = res_data;
        end else begin
          res_ready = 1'($urandom_range(0, 1));
          res_prev_valid = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int len, input int gd, input bit fg, input bit stl,
                               input bit pulse_mid, input bit abort);
    logic [39:0] exp_w[$];
    logic [31:0] exp_r[$];
    int cyc;
    int done0;
    int nmin;
    exp_w = {};
    exp_r = {};
    foreach (ops_in[i]) begin
      exp_w.push_back({8'h10, ops_in[i]});
      exp_r.push_back(fact(ops_in[i]));
    end
    exp_w.push_back({8'h00, 32'h1});
    exp_w.push_back({8'h04, 32'h1});
    writes = {}; results = {}; fifo_m = {};
    ops_pend = ops_in;
    reads = 0; proto_viol = 0; hold_viol = 0; busy_drop = 0;
    gdelay = gd; force_grant = fg; stall = stl;
    irq_block = abort;
    irq_early = abort ? 1'b0 : 1'($urandom_range(0, 2) == 0);
    done0 = done_cnt;
    @(negedge clk); #1;
    start = 1'b1;
    job_len = len[3:0];
    job_active = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    cyc = 0;
    while (done_cnt == done0 && cyc < 4000) begin
      @(negedge clk); #1;
      cyc++;
      if (pulse_mid && cyc == 6) begin start = 1'b1; job_len = 4'd3; end
      if (pulse_mid && cyc == 7) start = 1'b0;
      if (abort && in_wait) begin
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_ctl_outputs", {M0_req, M0_wr, op_ready, res_valid, busy, done}, 0);
        checkOutput("reset_address", M0_address, 0);
        checkOutput("reset_dout", M0_dout, 0);
        checkOutput("reset_res_data", res_data, 0);
        checkOutput("abort_no_done", done_cnt - done0, 0);
        job_active = 1'b0; in_wait = 1'b0; irq_block = 1'b0;
        interrupt = 1'b0; fifo_m = {}; ops_pend = {};
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
    end
    if (abort) checkOutput("abort_reached_wait", 0, 1);
    checkOutput("job_finished", done_cnt - done0, 1);
    @(negedge clk); #1;
    checkOutput("done_single_pulse", {done, 31'(done_cnt - done0)}, {1'b0, 31'd1});
    checkOutput("busy_after_done", busy, 0);
    checkOutput("write_count", writes.size(), exp_w.size());
    nmin = (writes.size() < exp_w.size()) ? writes.size() : exp_w.size();
    for (int i = 0; i < nmin; i++)
      checkOutput($sformatf("write%0d", i), writes[i], exp_w[i]);
    checkOutput("read_count", reads, len);
    checkOutput("result_count", results.size(), exp_r.size());
    nmin = (results.size() < exp_r.size()) ? results.size() : exp_r.size();
    for (int i = 0; i < nmin; i++)
      checkOutput($sformatf("result%0d", i), results[i], exp_r[i]);
    checkOutput("bus_protocol", proto_viol, 0);
    checkOutput("result_hold", hold_viol, 0);
    checkOutput("busy_throughout", busy_drop, 0);
    job_active = 1'b0;
  endtask

  task automatic applyBadStart(input logic [3:0] len);
    int done0;
    int busy_seen;
    done0 = done_cnt;
    req_cnt = 0;
    busy_seen = 0;
    @(negedge clk); #1;
    start = 1'b1;
    job_len = len;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (busy) busy_seen++;
    end
    checkOutput($sformatf("bad_len%0d_busy", len), busy_seen, 0);
    checkOutput($sformatf("bad_len%0d_req", len), req_cnt, 0);
    checkOutput($sformatf("bad_len%0d_done", len), done_cnt - done0, 0);
  endtask

  initial begin : main
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ctl", {M0_req, M0_wr, op_ready, res_valid, busy, done}, 0);
    checkOutput("rst_bus", {M0_address, M0_dout}, 0);
    checkOutput("rst_res_data", res_data, 0);
    reset_n = 1'b1;

    ops_in = {32'd5};
    applyStimulus(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    ops_in = {};
    for (int i = 1; i <= 8; i++) ops_in.push_back(32'(i));
    applyStimulus(8, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    ops_in = {32'd7, 32'd3, 32'd10};
    applyStimulus(3, 1, 1'b0, 1'b1, 1'b0, 1'b0);

    applyBadStart(4'd0);
    applyBadStart(4'd9);

    ops_in = {32'd4, 32'd6, 32'd2};
    applyStimulus(3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    ops_in = {32'd3, 32'd9};
    applyStimulus(2, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    ops_in = {32'd1, 32'd2, 32'd11, 32'd12};
    applyStimulus(4, 0, 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (6) begin
      n = $urandom_range(1, 8);
      ops_in = {};
      for (int i = 0; i < n; i++) ops_in.push_back(32'($urandom_range(0, 12)));
      applyStimulus(n, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
